avl_rd_chan: RTL and testbench
==============================

AVL_RD_CHAN -- requirements
Module: avl_rd_chan

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 27, Avalon line address width (64-byte units).
REQ-002 SHALL have parameter DATA_WIDTH, default 512, line width in bits.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, request length width in lines.
REQ-004 SHALL have parameter MAX_BURST, default 8, maximum burstcount per Avalon read, range 1..64.
REQ-005 SHALL have parameter FIFO_DEPTH, default 32, read data buffer depth in lines, power of two, at least MAX_BURST.
REQ-006 SHALL have ports in this order:
- clk  input  1  sole clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request offered.
- req_ready  output  1  request accepted when high with req_valid.
- req_addr  input  ADDR_WIDTH  first line address.
- req_len  input  LEN_WIDTH  number of lines.
- rd_data  output  DATA_WIDTH  returned line.
- rd_last  output  1  final line of the current request.
- rd_valid  output  1  rd_data valid.
- rd_ready  input  1  consumer accepts the line.
- m_address  output  ADDR_WIDTH  Avalon address.
- m_read  output  1  Avalon read.
- m_waitrequest  input  1  Avalon stall.
- m_burstcount  output  7  Avalon burst length.
- m_readdata  input  DATA_WIDTH  Avalon read data.
- m_readdatavalid  input  1  Avalon data beat.
- m_write  output  1  tied 0.
- m_writedata  output  DATA_WIDTH  tied 0.
- m_be  output  DATA_WIDTH/8  tied all ones.
- busy  output  1  high whenever state is not IDLE or the FIFO is non-empty.

Function
REQ-007 SHALL implement a state machine with states IDLE, ISSUE and DRAIN, with req_ready = (state == IDLE).
REQ-008 IDLE handling of a request:
- On req_valid with req_len != 0: latch addr and len, set remaining = len, rx_cnt = 0, go to ISSUE.
- On req_valid with req_len == 0: accept the request, produce no reads and no data, stay in IDLE.
REQ-009 In ISSUE, the burst size SHALL be burst = min(remaining, MAX_BURST).
REQ-010 In ISSUE, m_read SHALL assert only when credit = FIFO_DEPTH - fifo_count - outstanding is at least burst; otherwise m_read SHALL stay low.
REQ-011 While m_read = 1 and m_waitrequest = 1, m_read, m_address and m_burstcount SHALL hold stable.
REQ-012 On a burst acceptance (m_read & ~m_waitrequest), the block SHALL apply the following in the same edge:
- m_address += burst;
- remaining -= burst;
- outstanding += burst;
- m_read deasserts for at least one cycle;
- if remaining reaches 0, go to DRAIN.
REQ-013 Each m_readdatavalid beat SHALL write {m_readdata, last} into the FIFO, decrement outstanding and increment rx_cnt.
REQ-014 The last flag of a beat SHALL be 1 exactly when rx_cnt == len-1.
REQ-015 A burst acceptance and a data beat in the same cycle SHALL net outstanding += burst-1.
REQ-016 In DRAIN, the block SHALL go to IDLE on the cycle outstanding reaches 0; the FIFO may still hold data, and the next request may start.
REQ-017 The FIFO output SHALL drive rd_data, rd_last and rd_valid (show-ahead), and SHALL pop on rd_valid & rd_ready.
REQ-018 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-019 The credit rule SHALL guarantee the FIFO never overflows.
REQ-020 A beat arriving while the FIFO is full SHALL be flagged as a simulation assertion error.
REQ-021 m_address SHALL wrap modulo 2^ADDR_WIDTH, with no boundary splitting.
REQ-022 outstanding SHALL be ceil(log2(FIFO_DEPTH+1)) bits wide; fifo_count SHALL be the same width.

Reset
REQ-023 While reset = 1, the block SHALL hold:
- state = IDLE, req_ready = 1;
- m_read = 0, m_address = 0, m_burstcount = 0;
- rd_valid = 0, rd_last = 0, rd_data = 0;
- busy = 0;
- FIFO empty, outstanding = 0, remaining = 0, rx_cnt = 0.
REQ-024 Reset asserted mid-transfer SHALL discard all buffered and outstanding data.
REQ-025 Any m_readdatavalid received after reset deassertion that belongs to pre-reset bursts is outside the contract and SHALL NOT be required to be handled; the interconnect shares this reset.

Verification
REQ-026 Single-burst request: req_addr = 0x100, req_len = 5, no waitrequest -> one read with m_address 0x100 and burstcount 5; 5 lines out; rd_last on the 5th only.
REQ-027 Multi-burst request: req_len = 20, MAX_BURST = 8 -> bursts of 8, 8 and 4 at addresses A, A+8 and A+16; 20 lines out in order; return to IDLE after the last beat.
REQ-028 Backpressure: rd_ready held 0, req_len = 64, FIFO_DEPTH = 32 -> exactly 32 lines requested, then m_read stays 0; releasing rd_ready resumes issue; all 64 lines delivered with no overflow.
REQ-029 Waitrequest: m_waitrequest high for 3 cycles on the first burst -> address and burstcount stable during the stall; one acceptance only.
REQ-030 Edge cases:
- req_len = 0 -> accepted in one cycle, no m_read, no rd_valid.
- Acceptance and beat in the same cycle -> outstanding increases by burst-1.
REQ-031 Reset mid-transfer: reset asserted after 3 of 8 beats -> all outputs match REQ-023 immediately; a following request of len 2 completes correctly.

Source files
------------

// File: rtl/avl_rd_chan.sv
// rtl/avl_rd_chan.sv - Avalon-MM burst read channel feeding a show-ahead line buffer
// Splits line requests into credit-limited bursts and returns the lines in order with a last flag.
module avl_rd_chan #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic                    m_read,
  input  logic                    m_waitrequest,
  output logic [6:0]              m_burstcount,
  input  logic [DATA_WIDTH-1:0]   m_readdata,
  input  logic                    m_readdatavalid,
  output logic                    m_write,
  output logic [DATA_WIDTH-1:0]   m_writedata,
  output logic [DATA_WIDTH/8-1:0] m_be,
  output logic                    busy
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int KW = CW + 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  read_q, read_d;
  logic [6:0]            bcnt_q, bcnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]  rx_cnt_q, rx_cnt_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];

  logic [6:0]    burst;
  logic [KW-1:0] credit;
  logic          accept, full, push, pop, beat_last;

  always_comb begin
    burst     = (remaining_q < LEN_WIDTH'(MAX_BURST)) ? 7'(remaining_q) : 7'(MAX_BURST);
    // Lines already buffered plus lines in flight must never exceed the buffer.
    credit    = KW'(FIFO_DEPTH) - KW'(count_q) - KW'(outstanding_q);
    accept    = read_q & ~m_waitrequest;
    full      = (count_q == CW'(FIFO_DEPTH));
    push      = m_readdatavalid & ~full;
    pop       = (count_q != '0) & rd_ready;
    beat_last = (rx_cnt_q == len_q - LEN_WIDTH'(1));

    state_d     = state_q;
    addr_d      = addr_q;
    read_d      = read_q;
    bcnt_d      = bcnt_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    rx_cnt_d    = rx_cnt_q;

    outstanding_d = outstanding_q;
    if (accept)          outstanding_d = outstanding_d + CW'(bcnt_q);
    if (m_readdatavalid) outstanding_d = outstanding_d - CW'(1);
    if (m_readdatavalid) rx_cnt_d = rx_cnt_q + LEN_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (req_valid && req_len != '0) begin
          addr_d      = req_addr;
          len_d       = req_len;
          remaining_d = req_len;
          rx_cnt_d    = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          addr_d      = addr_q + ADDR_WIDTH'(bcnt_q);
          remaining_d = remaining_q - LEN_WIDTH'(bcnt_q);
          read_d      = 1'b0;
          if (remaining_d == '0) state_d = DRAIN;
        end else if (!read_q && credit >= KW'(burst)) begin
          read_d = 1'b1;
          bcnt_d = burst;
        end
      end
      DRAIN: begin
        if (outstanding_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      read_q        <= 1'b0;
      bcnt_q        <= '0;
      len_q         <= '0;
      remaining_q   <= '0;
      rx_cnt_q      <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      read_q        <= read_d;
      bcnt_q        <= bcnt_d;
      len_q         <= len_d;
      remaining_q   <= remaining_d;
      rx_cnt_q      <= rx_cnt_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {m_readdata, beat_last};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) m_readdatavalid |-> !full);

  assign req_ready    = (state_q == IDLE);
  assign m_address    = addr_q;
  assign m_read       = read_q;
  assign m_burstcount = bcnt_q;
  assign rd_valid     = (count_q != '0);
  assign rd_data      = rd_valid ? mem_q[rd_ptr_q][DATA_WIDTH:1] : '0;
  assign rd_last      = rd_valid ? mem_q[rd_ptr_q][0] : 1'b0;
  assign m_write      = 1'b0;
  assign m_writedata  = '0;
  assign m_be         = '1;
  assign busy         = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_avl_rd_chan.sv
// tb/tb_avl_rd_chan.sv - self-checking bench for avl_rd_chan
// Request-level model of bursts and returned lines, checked every cycle, plus literal scenario checks.
module tb_avl_rd_chan;
  localparam int AW = 27;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int MB = 8;
  localparam int FD = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, rd_last, rd_valid, rd_ready;
  logic [AW-1:0] req_addr, m_address;
  logic [LW-1:0] req_len;
  logic [DW-1:0] rd_data, m_readdata, m_writedata;
  logic          m_read, m_waitrequest, m_readdatavalid, m_write, busy;
  logic [6:0]    m_burstcount;
  logic [DW/8-1:0] m_be;

  avl_rd_chan #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_BURST(MB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest), .m_burstcount(m_burstcount),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .m_write(m_write),
    .m_writedata(m_writedata), .m_be(m_be), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
    return DW'(a) ^ 32'hC0DE_0000;
  endfunction

  typedef struct { logic [AW-1:0] a; int n; } burst_t;
  typedef struct { logic [DW-1:0] d; logic l; } line_t;

  burst_t        exp_burst[$];
  burst_t        log_q[$];
  line_t         exp_lines[$];
  logic [AW-1:0] slv_q[$];

  int fifo_m = 0, outs_m = 0;
  int acc_beats = 0, beats = 0, lines_out = 0, lasts_out = 0;
  int stalls = 0, read_cyc = 0, rdv_cyc = 0;
  int stall_left = 0;
  bit prev_acc = 0, prev_stall = 0;
  logic [AW-1:0] prev_addr;
  logic [6:0]    prev_bc;

  // Model: what the channel must look like given everything observed so far.
  always @(negedge clk) begin : model
    bit acc;
    int rem, off, n;
    if (rst) begin
      exp_burst.delete();
      exp_lines.delete();
      slv_q.delete();
      fifo_m = 0; outs_m = 0; prev_acc = 0; prev_stall = 0;
    end else begin
      acc = m_read && !m_waitrequest;
      chk("req_ready", req_ready, (exp_burst.size() == 0 && outs_m == 0));
      chk("busy", busy, (exp_burst.size() != 0 || outs_m != 0 || fifo_m != 0));
      chk("outstanding", dut.outstanding_q, outs_m);
      chk("rd_valid", rd_valid, fifo_m != 0);
      if (rd_valid && exp_lines.size() != 0) begin
        chk("rd_data", rd_data, exp_lines[0].d);
        chk("rd_last", rd_last, exp_lines[0].l);
      end
      if (prev_acc) chk("read_gap", m_read, 0);
      if (prev_stall) begin
        chk("stall_read", m_read, 1);
        chk("stall_addr", m_address, prev_addr);
        chk("stall_bc", m_burstcount, prev_bc);
      end
      if (m_read) begin
        read_cyc++;
        if (exp_burst.size() == 0) chk("unexpected_read", m_read, 0);
        else begin
          chk("burst_addr", m_address, exp_burst[0].a);
          chk("burst_bc", m_burstcount, exp_burst[0].n);
          chk("credit", (FD - fifo_m - outs_m) >= int'(m_burstcount), 1);
        end
      end
      if (m_read && m_waitrequest) stalls++;
      if (acc) begin
        if (exp_burst.size() != 0) void'(exp_burst.pop_front());
        log_q.push_back('{a: m_address, n: int'(m_burstcount)});
        outs_m += int'(m_burstcount);
        acc_beats += int'(m_burstcount);
        for (int i = 0; i < int'(m_burstcount); i++) slv_q.push_back(m_address + AW'(i));
      end
      if (m_readdatavalid) begin
        outs_m--; fifo_m++; beats++;
      end
      if (rd_valid) rdv_cyc++;
      if (rd_valid && rd_ready) begin
        if (exp_lines.size() != 0) void'(exp_lines.pop_front());
        if (fifo_m > 0) fifo_m--;
        lines_out++;
        if (rd_last) lasts_out++;
      end
      if (req_valid && req_ready && req_len != '0) begin
        rem = int'(req_len);
        off = 0;
        while (rem > 0) begin
          n = (rem < MB) ? rem : MB;
          exp_burst.push_back('{a: req_addr + AW'(off), n: n});
          rem -= n;
          off += n;
        end
        for (int i = 0; i < int'(req_len); i++)
          exp_lines.push_back('{d: line_of(req_addr + AW'(i)), l: (i == int'(req_len) - 1)});
      end
      prev_acc   = acc;
      prev_stall = m_read && m_waitrequest;
      prev_addr  = m_address;
      prev_bc    = m_burstcount;
    end
  end

  // Avalon slave: one beat per cycle from accepted bursts, optional waitrequest stall.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_readdatavalid = 1'b0;
      m_readdata      = '0;
      m_waitrequest   = 1'b0;
      slv_q.delete();
    end else begin
      m_waitrequest = (stall_left > 0);
      if (m_read && stall_left > 0) stall_left--;
      if (slv_q.size() != 0) begin
        m_readdatavalid = 1'b1;
        m_readdata      = line_of(slv_q.pop_front());
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [AW-1:0] a, input logic [LW-1:0] l);
    bit got = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    for (int i = 0; i < 50 && !got; i++) begin
      got = req_ready;
      step();
    end
    req_valid = 1'b0;
    chk("req_accept", got, 1);
  endtask

  task automatic wait_lines(input int target, input string name);
    for (int i = 0; i < 3000 && lines_out < target; i++) step();
    chk(name, lines_out, target);
  endtask

  task automatic wait_beats(input int target, input string name);
    for (int i = 0; i < 3000 && beats < target; i++) step();
    chk(name, beats, target);
  endtask

  task automatic chk_reset();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_m_read", m_read, 0);
    chk("rst_m_address", m_address, 0);
    chk("rst_m_burstcount", m_burstcount, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outstanding", dut.outstanding_q, 0);
    chk("m_write", m_write, 0);
    chk("m_writedata", m_writedata, 0);
    chk("m_be", m_be, 4'hF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, l0, t0, k0, a0, s0, r0, v0;
    req_valid = 1'b0; req_addr = '0; req_len = '0; rd_ready = 1'b1;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
    rst = 1'b1;
    repeat (3) step();
    chk_reset();
    rst = 1'b0;
    step();

    // Single burst
    b0 = log_q.size(); l0 = lines_out; t0 = lasts_out;
    send_req(27'h100, 16'd5);
    wait_lines(l0 + 5, "a_lines");
    chk("a_nbursts", log_q.size() - b0, 1);
    chk("a_addr", log_q[b0].a, 27'h100);
    chk("a_bc", log_q[b0].n, 5);
    chk("a_lasts", lasts_out - t0, 1);

    // Three bursts, idle right after the final beat
    b0 = log_q.size(); l0 = lines_out; k0 = beats;
    send_req(27'h2000, 16'd20);
    wait_beats(k0 + 20, "b_beats");
    chk("b_idle_after_last", req_ready, 1);
    wait_lines(l0 + 20, "b_lines");
    chk("b_nbursts", log_q.size() - b0, 3);
    chk("b_addr0", log_q[b0].a, 27'h2000);
    chk("b_bc0", log_q[b0].n, 8);
    chk("b_addr1", log_q[b0+1].a, 27'h2008);
    chk("b_bc1", log_q[b0+1].n, 8);
    chk("b_addr2", log_q[b0+2].a, 27'h2010);
    chk("b_bc2", log_q[b0+2].n, 4);

    // Three-cycle waitrequest on the first burst
    b0 = log_q.size(); l0 = lines_out; s0 = stalls;
    stall_left = 3;
    send_req(27'h3000, 16'd6);
    wait_lines(l0 + 6, "c_lines");
    chk("c_stalls", stalls - s0, 3);
    chk("c_nbursts", log_q.size() - b0, 1);
    chk("c_addr", log_q[b0].a, 27'h3000);
    chk("c_bc", log_q[b0].n, 6);

    // Address wrap at the top of the space
    b0 = log_q.size(); l0 = lines_out;
    send_req(27'h7FFFFFC, 16'd10);
    wait_lines(l0 + 10, "w_lines");
    chk("w_nbursts", log_q.size() - b0, 2);
    chk("w_addr0", log_q[b0].a, 27'h7FFFFFC);
    chk("w_bc0", log_q[b0].n, 8);
    chk("w_addr1", log_q[b0+1].a, 27'h0000004);
    chk("w_bc1", log_q[b0+1].n, 2);

    // Zero-length request
    r0 = read_cyc; v0 = rdv_cyc;
    req_valid = 1'b1; req_addr = 27'h5000; req_len = '0;
    chk("z_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    repeat (10) step();
    chk("z_no_read", read_cyc - r0, 0);
    chk("z_no_data", rdv_cyc - v0, 0);
    chk("z_busy", busy, 0);

    // Consumer backpressure bounds issue to the buffer depth
    rd_ready = 1'b0;
    a0 = acc_beats; l0 = lines_out;
    send_req(27'h4000, 16'd64);
    repeat (200) step();
    chk("p_requested", acc_beats - a0, 32);
    chk("p_read_low", m_read, 0);
    chk("p_rd_valid", rd_valid, 1);
    rd_ready = 1'b1;
    wait_lines(l0 + 64, "p_lines");
    chk("p_total", acc_beats - a0, 64);

    // Reset after three of eight beats, then a short request
    k0 = beats;
    send_req(27'h6000, 16'd8);
    wait_beats(k0 + 3, "r_beats");
    rst = 1'b1;
    #1;
    chk_reset();
    repeat (2) step();
    rst = 1'b0;
    step();
    b0 = log_q.size(); l0 = lines_out; t0 = lasts_out;
    send_req(27'h6100, 16'd2);
    wait_lines(l0 + 2, "r_lines");
    chk("r_nbursts", log_q.size() - b0, 1);
    chk("r_addr", log_q[b0].a, 27'h6100);
    chk("r_bc", log_q[b0].n, 2);
    chk("r_lasts", lasts_out - t0, 1);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
